// File: rtl/soc_adc_sched_pkg.sv
// Shared state encoding and default widths for the aux-ADC scheduler and its arbiter.
package soc_adc_sched_pkg;

    localparam int DW_DEF    = 10;
    localparam int NREQ_DEF  = 4;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CONV   = 2'd2,
        ST_GAP    = 2'd3
    } sched_state_e;

endpackage

// File: rtl/soc_adc_rr_arb.sv
// Combinational round-robin arbiter: picks the first set req bit searching upward
// (with wrap) from last_grant+1.
module soc_adc_rr_arb
    import soc_adc_sched_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int SEL_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [SEL_W-1:0] last_grant,
    input  logic             enable,
    output logic             grant_vld,
    output logic [SEL_W-1:0] grant_idx
);

    logic [SEL_W-1:0] idx;

    // Walk from lowest to highest priority so the last hit is the winner.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = '0;
        for (int i = NREQ; i >= 1; i--) begin
            idx = SEL_W'((int'(last_grant) + i) % NREQ);
            if (enable && req[idx]) begin
                grant_vld = 1'b1;
                grant_idx = idx;
            end
        end
    end

endmodule

// File: rtl/soc_adc_scheduler.sv
// Time-multiplexes the aux ADC between NREQ requesters: arbitrate, settle the mux,
// convert, then hold adc_en low for a gap. Optional CONV timeout: SOC_ADC_SCHED_TIMEOUT_EN.
module soc_adc_scheduler
    import soc_adc_sched_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int NREQ    = NREQ_DEF,
    parameter int SEL_W   = $clog2(NREQ),
    parameter int CNT_W   = CNT_W_DEF,
    parameter int SETTLE  = 16,
    parameter int GAP     = 4,
    parameter int TIMEOUT = 200
) (
    input  logic             sys_slow_cbus_clk,
    input  logic             sys_slow_cbus_rst_n,
    input  logic             sched_en,
    input  logic [NREQ-1:0]  req,
    input  logic [DW-1:0]    adc_data,
    input  logic             adc_strb,
    output logic             adc_en,
    output logic [SEL_W-1:0] adc_ch_sel,
    output logic [NREQ-1:0]  rsp_valid,
    output logic [DW-1:0]    rsp_data,
    output logic             rsp_err,
    output logic             busy
);

    if (NREQ < 2 || NREQ > 8 || SETTLE < 1 || GAP < 1 || TIMEOUT < 1 ||
        SETTLE >= (1 << CNT_W) || GAP >= (1 << CNT_W) || TIMEOUT > (1 << CNT_W)) begin : g_param_err
        $error("soc_adc_scheduler: parameter out of range");
    end

    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] GAP_LD    = CNT_W'(GAP - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [SEL_W-1:0] LAST_RST  = SEL_W'(NREQ - 1);
`ifdef SOC_ADC_SCHED_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
`endif

    sched_state_e     state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [SEL_W-1:0] last_grant, last_grant_nxt, sel_nxt;
    logic [NREQ-1:0]  vld_nxt, grant_onehot;
    logic [DW-1:0]    data_nxt;
    logic             en_nxt, err_nxt;
    logic             grant_vld;
    logic [SEL_W-1:0] grant_idx;

    soc_adc_rr_arb #(
        .NREQ  (NREQ),
        .SEL_W (SEL_W)
    ) u_arb (
        .req        (req),
        .last_grant (last_grant),
        .enable     (sched_en),
        .grant_vld  (grant_vld),
        .grant_idx  (grant_idx)
    );

    assign grant_onehot = NREQ'(1) << adc_ch_sel;
    assign busy         = (state != ST_IDLE);

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        sel_nxt        = adc_ch_sel;
        last_grant_nxt = last_grant;
        en_nxt         = adc_en;
        vld_nxt        = '0;
        data_nxt       = rsp_data;
        err_nxt        = rsp_err;
        case (state)
            ST_IDLE: begin
                if (grant_vld) begin
                    sel_nxt   = grant_idx;
                    cnt_nxt   = SETTLE_LD;
                    state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt == '0) begin
                    en_nxt    = 1'b1;
                    state_nxt = ST_CONV;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            ST_CONV: begin
                // A strobe on the expiry cycle still delivers a normal sample.
                if (adc_strb) begin
                    data_nxt  = adc_data;
                    vld_nxt   = grant_onehot;
                    err_nxt   = 1'b0;
                    en_nxt    = 1'b0;
                    cnt_nxt   = GAP_LD;
                    state_nxt = ST_GAP;
                end
`ifdef SOC_ADC_SCHED_TIMEOUT_EN
                else if (cnt == TO_LAST) begin
                    data_nxt  = '0;
                    vld_nxt   = grant_onehot;
                    err_nxt   = 1'b1;
                    en_nxt    = 1'b0;
                    cnt_nxt   = GAP_LD;
                    state_nxt = ST_GAP;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
`endif
            end
            ST_GAP: begin
                if (cnt == '0) begin
                    last_grant_nxt = adc_ch_sel;
                    state_nxt      = ST_IDLE;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_slow_cbus_clk) begin
        if (!sys_slow_cbus_rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            adc_ch_sel <= '0;
            last_grant <= LAST_RST;
            adc_en     <= 1'b0;
            rsp_valid  <= '0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            adc_ch_sel <= sel_nxt;
            last_grant <= last_grant_nxt;
            adc_en     <= en_nxt;
            rsp_valid  <= vld_nxt;
            rsp_data   <= data_nxt;
            rsp_err    <= err_nxt;
        end
    end

endmodule
